// File: rtl/sram_pkg.sv
// ============================================================================
// sram_pkg : shared types and defaults for the 16-bit async SRAM controller
// Revision : 1.0
// ============================================================================
`default_nettype none

package sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int          SRAM_DW         = 16;
    localparam int          SRAM_AW_DEF     = 18;
    localparam int          WAIT_CYCLES_DEF = 5;
    localparam logic [31:0] BASE_ADDR_DEF   = 32'd1024;

endpackage

`default_nettype wire

// File: rtl/sram_wait_counter.sv
// ============================================================================
// sram_wait_counter : per-phase wait counter with terminal-count flag
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_wait_counter
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [3:0] c_LAST = 4'(WAIT_CYCLES - 1);

    logic [3:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 4'd0;
        end else if (i_clr) begin
            r_count <= 4'd0;
        end else if (i_en) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign o_tc = (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/sram_mem_controller.sv
// ============================================================================
// sram_mem_controller : splits 32-bit MEM-stage loads/stores into two 16-bit
//                       async SRAM accesses, stalling the pipeline via ready
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_mem_controller
    import sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
    parameter int          WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int          SRAM_AW     = SRAM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdEn,
    input  logic               wrEn,
    input  logic [31:0]        address,
    input  logic [31:0]        writeData,
    output logic [31:0]        readData,
    output logic               ready,
    output logic [SRAM_AW-1:0] sramAddr,
    output logic [SRAM_DW-1:0] sramDqOut,
    input  logic [SRAM_DW-1:0] sramDqIn,
    output logic               sramDqOe,
    output logic               sramWeN
);

    // Single-cycle phases cannot afford a recovery cycle, so WE# stays low.
    localparam logic c_RECOVER = (WAIT_CYCLES > 1);

    state_t               r_state;
    state_t               w_next;
    logic                 r_opWrite;
    logic [SRAM_AW-2:0]   r_wordIdx;
    logic [31:0]          r_wdata;
    logic [SRAM_DW-1:0]   r_lowHalf;
    logic [31:0]          r_readData;

    logic [31:0]          w_offset;
    logic                 w_unused;
    logic                 w_req;
    logic                 w_accept;
    logic                 w_inPhase;
    logic                 w_tc;
    logic                 w_clr;

    assign w_offset  = address - BASE_ADDR;
    assign w_unused  = ^{w_offset[31:SRAM_AW+1], w_offset[1:0]};
    assign w_req     = rdEn | wrEn;
    assign w_accept  = (r_state == ST_IDLE) && w_req;
    assign w_inPhase = (r_state == ST_LOW) || (r_state == ST_HIGH);
    assign w_clr     = !w_inPhase || w_tc;

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_clr),
        .i_en  (w_inPhase),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_req) w_next = ST_LOW;
            ST_LOW:  if (w_tc)  w_next = ST_HIGH;
            ST_HIGH: if (w_tc)  w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ready     = 1'b1;
        sramAddr  = '0;
        sramDqOut = '0;
        sramDqOe  = 1'b0;
        sramWeN   = 1'b1;
        case (r_state)
            ST_IDLE: ready = !w_req;
            ST_LOW: begin
                ready    = 1'b0;
                sramAddr = {r_wordIdx, 1'b0};
                if (r_opWrite) begin
                    sramDqOe  = 1'b1;
                    sramDqOut = r_wdata[15:0];
                    sramWeN   = w_tc && c_RECOVER;
                end
            end
            ST_HIGH: begin
                ready    = 1'b0;
                sramAddr = {r_wordIdx, 1'b1};
                if (r_opWrite) begin
                    sramDqOe  = 1'b1;
                    sramDqOut = r_wdata[31:16];
                    sramWeN   = w_tc && c_RECOVER;
                end
            end
            default: ready = 1'b1;
        endcase
    end

    // A simultaneous rdEn/wrEn is treated as a store.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opWrite <= 1'b0;
            r_wordIdx <= '0;
            r_wdata   <= '0;
        end else if (w_accept) begin
            r_opWrite <= wrEn;
            r_wordIdx <= w_offset[SRAM_AW:2];
            r_wdata   <= writeData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lowHalf  <= '0;
            r_readData <= '0;
        end else if (w_tc && !r_opWrite) begin
            if (r_state == ST_LOW) begin
                r_lowHalf <= sramDqIn;
            end else if (r_state == ST_HIGH) begin
                r_readData <= {sramDqIn, r_lowHalf};
            end
        end
    end

    assign readData = r_readData;

endmodule

`default_nettype wire

// File: tb/tb_sram_mem_controller.sv
// ============================================================================
// tb_sram_mem_controller : self-checking bench, WAIT_CYCLES=5 and =1 instances
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sram_mem_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        rd, wr;
    logic [31:0] addr, wdata;

    logic [31:0] rdata5, rdata1;
    logic        rdy5, rdy1, oe5, oe1, wen5, wen1;
    logic [17:0] sa5, sa1;
    logic [15:0] dqo5, dqo1, dqi5, dqi1;

    logic [31:0] o_rdata;
    logic        o_rdy, o_oe, o_wen;
    logic [17:0] o_sa;
    logic [15:0] o_dqo;

    logic [15:0] m5 [0:262143];
    logic [15:0] m1 [0:262143];
    logic [31:0] w5 [0:131071];
    logic [31:0] w1 [0:131071];
    logic [31:0] erd5, erd1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_mem_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(5), .SRAM_AW(18)) dut5 (
        .clk(clk), .rst(rst), .rdEn(rd & ~sel), .wrEn(wr & ~sel),
        .address(addr), .writeData(wdata), .readData(rdata5), .ready(rdy5),
        .sramAddr(sa5), .sramDqOut(dqo5), .sramDqIn(dqi5), .sramDqOe(oe5), .sramWeN(wen5)
    );

    sram_mem_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(1), .SRAM_AW(18)) dut1 (
        .clk(clk), .rst(rst), .rdEn(rd & sel), .wrEn(wr & sel),
        .address(addr), .writeData(wdata), .readData(rdata1), .ready(rdy1),
        .sramAddr(sa1), .sramDqOut(dqo1), .sramDqIn(dqi1), .sramDqOe(oe1), .sramWeN(wen1)
    );

    assign o_rdata = sel ? rdata1 : rdata5;
    assign o_rdy   = sel ? rdy1   : rdy5;
    assign o_oe    = sel ? oe1    : oe5;
    assign o_wen   = sel ? wen1   : wen5;
    assign o_sa    = sel ? sa1    : sa5;
    assign o_dqo   = sel ? dqo1   : dqo5;

    // Asynchronous SRAM models: write while WE# low, read data presented mid-cycle.
    always @(posedge clk) begin
        if (!wen5 && oe5) m5[sa5] <= dqo5;
        if (!wen1 && oe1) m1[sa1] <= dqo1;
    end

    always @(negedge clk) begin
        dqi5 <= m5[sa5];
        dqi1 <= m1[sa1];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_chk(input logic s);
        @(negedge clk);
        sel = s; rd = 1'b0; wr = 1'b0;
        #1;
        chk("idle_ready", {31'd0, o_rdy}, 32'd1);
        chk("idle_addr",  {14'd0, o_sa}, 32'd0);
        chk("idle_dqout", {16'd0, o_dqo}, 32'd0);
        chk("idle_oe",    {31'd0, o_oe}, 32'd0);
        chk("idle_we_n",  {31'd0, o_wen}, 32'd1);
    endtask

    task automatic do_access(input logic s, input logic r, input logic w,
                             input logic [31:0] a, input logic [31:0] d);
        int          nw;
        int          j;
        logic        hi;
        logic [31:0] off;
        logic [16:0] idx;
        nw  = s ? 1 : 5;
        off = a - 32'd1024;
        idx = off[18:2];
        @(negedge clk);
        sel = s; rd = r; wr = w; addr = a; wdata = d;
        #1;
        chk("req_ready", {31'd0, o_rdy}, 32'd0);
        chk("req_addr",  {14'd0, o_sa}, 32'd0);
        chk("req_rdata", o_rdata, s ? erd1 : erd5);
        for (int k = 1; k <= 2 * nw; k++) begin
            @(negedge clk);
            rd = 1'($urandom); wr = 1'($urandom); addr = $urandom; wdata = $urandom;
            #1;
            hi = (k > nw);
            j  = hi ? k - nw - 1 : k - 1;
            chk("busy_ready", {31'd0, o_rdy}, 32'd0);
            chk("sram_addr",  {14'd0, o_sa}, {14'd0, idx, hi});
            chk("dq_oe",      {31'd0, o_oe}, {31'd0, w});
            chk("we_n",       {31'd0, o_wen}, (w && !(j == nw - 1 && nw > 1)) ? 32'd0 : 32'd1);
            if (w) chk("dq_out", {16'd0, o_dqo}, hi ? {16'd0, d[31:16]} : {16'd0, d[15:0]});
        end
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        #1;
        if (w) begin
            if (s) w1[idx] = d; else w5[idx] = d;
        end else begin
            if (s) erd1 = w1[idx]; else erd5 = w5[idx];
        end
        chk("done_ready", {31'd0, o_rdy}, 32'd1);
        chk("done_rdata", o_rdata, s ? erd1 : erd5);
        chk("done_addr",  {14'd0, o_sa}, 32'd0);
        chk("done_oe",    {31'd0, o_oe}, 32'd0);
        chk("done_we_n",  {31'd0, o_wen}, 32'd1);
    endtask

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic        rr, rw, rs;

        for (int i = 0; i < 262144; i++) begin m5[i] = '0; m1[i] = '0; end
        for (int i = 0; i < 131072; i++) begin w5[i] = '0; w1[i] = '0; end
        erd5 = '0; erd1 = '0;
        rst = 1'b1; sel = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;

        tbl[0] = '{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'h00000000};
        tbl[1] = '{1'b1, 1'b0, 32'd1032, 32'h00000000, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 1'b1, 32'd1032, 32'h12345678, 32'hDEADBEEF};
        tbl[3] = '{1'b1, 1'b0, 32'd1032, 32'h00000000, 32'h12345678};
        tbl[4] = '{1'b0, 1'b1, 32'd1020, 32'hAABBCCDD, 32'h12345678};
        tbl[5] = '{1'b1, 1'b0, 32'd1020, 32'h00000000, 32'hAABBCCDD};
        tbl[6] = '{1'b0, 1'b1, 32'd1027, 32'h0BADF00D, 32'hAABBCCDD};
        tbl[7] = '{1'b1, 1'b0, 32'd1024, 32'h00000000, 32'h0BADF00D};
        tbl[8] = '{1'b1, 1'b0, 32'd1036, 32'h00000000, 32'h00000000};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_chk(1'b0);
        chk("rst_rdata5", o_rdata, 32'd0);
        idle_chk(1'b1);
        chk("rst_rdata1", o_rdata, 32'd0);

        for (int i = 0; i < 9; i++) begin
            do_access(1'b0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d);
            chk("tbl_rdata", o_rdata, tbl[i].exp_rd);
        end
        idle_chk(1'b0);

        // Fast instance: back-to-back accesses with no bubble between them.
        do_access(1'b1, 1'b0, 1'b1, 32'd1040, 32'hCAFEF00D);
        do_access(1'b1, 1'b1, 1'b0, 32'd1040, 32'h0);
        chk("w1_load", o_rdata, 32'hCAFEF00D);
        do_access(1'b1, 1'b0, 1'b1, 32'd1040, 32'h11112222);
        do_access(1'b1, 1'b1, 1'b0, 32'd1040, 32'h0);
        chk("w1_load2", o_rdata, 32'h11112222);
        idle_chk(1'b1);

        // Reset during the second cycle of the high phase of a load.
        @(negedge clk);
        sel = 1'b0; rd = 1'b1; wr = 1'b0; addr = 32'd1032;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            rd = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        erd5 = '0; erd1 = '0;
        chk("midrst_ready", {31'd0, o_rdy}, 32'd1);
        chk("midrst_we_n",  {31'd0, o_wen}, 32'd1);
        chk("midrst_oe",    {31'd0, o_oe}, 32'd0);
        chk("midrst_addr",  {14'd0, o_sa}, 32'd0);
        chk("midrst_rdata", o_rdata, 32'd0);
        do_access(1'b0, 1'b1, 1'b0, 32'd1032, 32'h0);

        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom);
            rr = 1'($urandom);
            rw = 1'($urandom);
            if (!rr && !rw) rr = 1'b1;
            ra = 32'd1024 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) ra = ra - 32'd64;
            do_access(rs, rr, rw, ra, $urandom);
            if ($urandom_range(0, 2) == 0) idle_chk(rs);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Sequences the off-chip 16-bit asynchronous SRAM on behalf of the MEM stage; it replaces the single-cycle data memory.
- Splits each 32-bit load/store into two 16-bit SRAM accesses, each held for a programmable number of wait cycles.
- Drives `ready` low while busy; the top level ORs `~ready` into the freeze of every pipeline register and the hazard freeze.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 5: cycles each 16-bit half is held on the SRAM bus. Legal range 1..15.
- SRAM_AW, 18: SRAM address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rdEn  in  1  load request from MEM stage.
- wrEn  in  1  store request from MEM stage.
- address  in  32  byte address (ALU result).
- writeData  in  32  store data (valRm).
- readData  out  32  load result; registered.
- ready  out  1  low = stall the pipeline.
- sramAddr  out  SRAM_AW  SRAM half-word address.
- sramDqOut  out  16  data driven to SRAM.
- sramDqIn  in  16  data returned from SRAM.
- sramDqOe  out  1  1 = controller drives the DQ bus.
- sramWeN  out  1  active-low write enable.

Behaviour:
- Reset values:
  - state IDLE, counter 0, readData 0.
  - sramAddr 0, sramDqOut 0, sramDqOe 0, sramWeN 1.
- Any cycle with rst=1 forces these values, including mid-transaction. The in-flight access is abandoned and no readData update occurs.
- States and transitions:
  - IDLE -> LOW when (rdEn|wrEn).
  - LOW -> HIGH after WAIT_CYCLES cycles.
  - HIGH -> DONE after WAIT_CYCLES cycles.
  - DONE -> IDLE unconditionally.
- The request is latched on the IDLE->LOW edge: op, word index, writeData.
- Inputs are ignored outside IDLE.
- Word index = (address - BASE_ADDR) mod 2^32, bits [18:2]. address[1:0] is ignored (word aligned).
- Addresses below BASE_ADDR wrap silently; no error is raised.
- sramAddr:
  - {wordIdx, 1'b0} in LOW (low half).
  - {wordIdx, 1'b1} in HIGH (high half).
  - 0 otherwise.
- Counter:
  - 4-bit; cleared on entry to LOW and HIGH; increments each cycle in those states.
  - The phase ends in the cycle where counter == WAIT_CYCLES-1.
- Store:
  - sramDqOe=1 for the whole of LOW and HIGH.
  - sramDqOut = writeData[15:0] in LOW, writeData[31:16] in HIGH.
  - sramWeN=0 in every phase cycle except the last one of each phase (write recovery). With WAIT_CYCLES=1, sramWeN stays 0 for that single cycle.
- Load:
  - sramDqOe=0 and sramWeN=1 throughout.
  - sramDqIn is sampled on the last cycle of LOW into the low half-register and on the last cycle of HIGH into readData[31:16].
  - readData[15:0] is loaded at the same HIGH edge.
  - readData holds until the next load completes; stores never change it.
- ready (combinational):
  - 1 in IDLE with no request.
  - 0 in IDLE with a request, and in LOW and HIGH.
  - 1 in DONE.
- Latency: a request first seen in cycle t gives ready=1 in cycle t+2·WAIT_CYCLES+1. For the default (5) that is t+11.
- Pipeline freeze therefore lasts exactly 2·WAIT_CYCLES+1 cycles per access.
- DONE lasts one cycle. The pipeline advances on its closing edge, so the same instruction never retriggers.
- Simultaneous rdEn and wrEn: the write wins and readData is unchanged.
- Back-to-back memory instructions: the second request is seen in the IDLE cycle immediately after DONE. There are no idle bubbles beyond that.
- No request in IDLE: all SRAM outputs stay at their reset values.

Decomposition:
- Shared package `sram_pkg`:
  - state enum {IDLE, LOW, HIGH, DONE};
  - SRAM data width (16) and SRAM_AW default;
  - BASE_ADDR default.
- Sub-module `sram_wait_counter`: clear/enable/terminal-count for phase timing, parameterised by WAIT_CYCLES.
- FSM, address generation and data capture stay in the top module.

Test Plan:
- Reset: hold rst 3 cycles, then release -> ready=1, sramWeN=1, sramDqOe=0, readData=0.
- Store (WAIT_CYCLES=5): wrEn, address=1032, writeData=0xDEADBEEF at t ->
  - t+1..t+5: sramAddr=4, sramDqOut=0xBEEF, sramWeN=0 for t+1..t+4 and 1 at t+5;
  - t+6..t+10: sramAddr=5, sramDqOut=0xDEAD;
  - ready=1 only at t+11.
- Load: rdEn, address=1032, SRAM model returns 0xBEEF/0xDEAD -> readData=0xDEADBEEF at t+11 and held through a following store.
- Simultaneous rdEn=wrEn=1 with writeData=0x12345678 -> store sequence performed; readData unchanged.
- Reset mid-operation: assert rst in HIGH phase cycle 2 -> next cycle IDLE, sramWeN=1, sramDqOe=0, readData unchanged from pre-request value (0 after reset).
- WAIT_CYCLES=1, back-to-back load then store -> each access ready=1 at t+3. Second request accepted the cycle after DONE. sramWeN=0 for one cycle per half.
